i_decode: RTL and testbench

- Instruction-decode stage directly downstream of the fetch stage.
- Consumes IF_ID_INSTR/IF_ID_NPC, reads a 32x32 register file and sign-extends the immediate.
- Registers all results into the ID/EX pipeline register.
- Accepts the MEM/WB write-back, detects load-use hazards (stalls fetch) and inserts a bubble on a taken branch.

---
 rtl/i_decode_pkg.sv | 43 ++++
 rtl/i_decode_reg_file.sv | 52 +++++
 rtl/i_decode.sv | 141 ++++++++++++++
 tb/tb_i_decode.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/i_decode_pkg.sv
// Shared decode constants for the instruction-decode stage: opcodes, field
// bit positions and the ID/EX control bundle.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam int unsigned OPC_MSB   = 31;
    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned IMM_LSB   = 0;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic valid;
    } idex_ctrl_t;

    function automatic idex_ctrl_t decode_ctrl(input logic [5:0] opcode);
        idex_ctrl_t c;
        c       = '0;
        c.valid = 1'b1;
        case (opcode)
            OP_RTYPE, OP_ADDI: c.regwrite = 1'b1;
            OP_LW: begin
                c.regwrite = 1'b1;
                c.memread  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i_decode_reg_file.sv
// NREGS x DW register file, two async read ports, one sync write port, reg 0 reads zero.
// Define ID_WB_BYPASS_EN to forward a same-cycle write to the read ports.
module reg_file #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] regs_q [NREGS];
    logic          wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '{default: '0};
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (raddr_a_i != '0) begin
            rdata_a_o = regs_q[raddr_a_i];
        end
        if (raddr_b_i != '0) begin
            rdata_b_o = regs_q[raddr_b_i];
        end
`ifdef ID_WB_BYPASS_EN
        // wr_en already excludes reg 0, so forwarding never breaks the zero register
        if (wr_en && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end
        if (wr_en && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end
`endif
    end

endmodule

// File: rtl/i_decode.sv
// Instruction-decode stage: field split, register read, immediate extension,
// load-use stall and branch flush into the ID/EX register. Option: ID_WB_BYPASS_EN.
module i_decode
    import id_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [31:0]   IF_ID_INSTR,
    input  logic [31:0]   IF_ID_NPC,
    input  logic          EX_MEM_PCSrc,
    input  logic          MEM_WB_REGWRITE,
    input  logic [4:0]    MEM_WB_RD,
    input  logic [DW-1:0] MEM_WB_DATA,
    output logic          ID_STALL,
    output logic [31:0]   ID_EX_NPC,
    output logic [DW-1:0] ID_EX_A,
    output logic [DW-1:0] ID_EX_B,
    output logic [31:0]   ID_EX_IMM,
    output logic [4:0]    ID_EX_RT,
    output logic [4:0]    ID_EX_RD,
    output logic [5:0]    ID_EX_OPCODE,
    output logic [5:0]    ID_EX_FUNCT,
    output logic          ID_EX_REGWRITE,
    output logic          ID_EX_MEMREAD,
    output logic          ID_EX_VALID
);

    logic [5:0]    opcode;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;

    logic [31:0]   npc_q, npc_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [31:0]   imm_q, imm_d;
    logic [4:0]    rt_q, rt_d;
    logic [4:0]    rd_q, rd_d;
    logic [5:0]    opc_q, opc_d;
    logic [5:0]    funct_q, funct_d;
    idex_ctrl_t    ctrl_q, ctrl_d;
    logic          stall;

    assign opcode = IF_ID_INSTR[OPC_MSB:OPC_LSB];
    assign rs     = IF_ID_INSTR[RS_MSB:RS_LSB];
    assign rt     = IF_ID_INSTR[RT_MSB:RT_LSB];
    assign rd     = IF_ID_INSTR[RD_MSB:RD_LSB];
    assign funct  = IF_ID_INSTR[FUNCT_MSB:FUNCT_LSB];
    assign imm    = IF_ID_INSTR[IMM_MSB:IMM_LSB];

    reg_file #(
        .NREGS(NREGS),
        .DW   (DW)
    ) u_reg_file (
        .clk_i    (CLK),
        .rst_i    (RST),
        .we_i     (MEM_WB_REGWRITE),
        .waddr_i  (MEM_WB_RD),
        .wdata_i  (MEM_WB_DATA),
        .raddr_a_i(rs),
        .rdata_a_o(rs_val),
        .raddr_b_i(rt),
        .rdata_b_o(rt_val)
    );

    // Flush and reset both suppress the stall so fetch is never held by a dead load
    always_comb begin
        stall = 1'b0;
        if (!RST && !EX_MEM_PCSrc && ctrl_q.valid && ctrl_q.memread && (rt_q != '0)) begin
            stall = (rt_q == rs) || (rt_q == rt);
        end
    end

    always_comb begin
        npc_d   = '0;
        a_d     = '0;
        b_d     = '0;
        imm_d   = '0;
        rt_d    = '0;
        rd_d    = '0;
        opc_d   = '0;
        funct_d = '0;
        ctrl_d  = '0;
        if (!EX_MEM_PCSrc && !stall) begin
            npc_d   = IF_ID_NPC;
            a_d     = rs_val;
            b_d     = rt_val;
            imm_d   = {{16{imm[15]}}, imm};
            rt_d    = rt;
            rd_d    = rd;
            opc_d   = opcode;
            funct_d = funct;
            ctrl_d  = decode_ctrl(opcode);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            npc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            opc_q   <= '0;
            funct_q <= '0;
            ctrl_q  <= '0;
        end else begin
            npc_q   <= npc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            opc_q   <= opc_d;
            funct_q <= funct_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ID_STALL       = stall;
    assign ID_EX_NPC      = npc_q;
    assign ID_EX_A        = a_q;
    assign ID_EX_B        = b_q;
    assign ID_EX_IMM      = imm_q;
    assign ID_EX_RT       = rt_q;
    assign ID_EX_RD       = rd_q;
    assign ID_EX_OPCODE   = opc_q;
    assign ID_EX_FUNCT    = funct_q;
    assign ID_EX_REGWRITE = ctrl_q.regwrite;
    assign ID_EX_MEMREAD  = ctrl_q.memread;
    assign ID_EX_VALID    = ctrl_q.valid;

endmodule

// File: tb/tb_i_decode.sv
// Directed, table-driven bench for i_decode; expected values are hand-computed.
module tb_i_decode;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
        logic        stall;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  opc;
        logic [5:0]  funct;
        logic        rw;
        logic        mr;
        logic        valid;
    } vec_t;

`ifdef ID_WB_BYPASS_EN
    localparam logic [31:0] EXP_BYP = 32'h0000_00AA;
`else
    localparam logic [31:0] EXP_BYP = 32'h0000_0005;
`endif

    logic        CLK;
    logic        RST;
    logic [31:0] IF_ID_INSTR;
    logic [31:0] IF_ID_NPC;
    logic        EX_MEM_PCSrc;
    logic        MEM_WB_REGWRITE;
    logic [4:0]  MEM_WB_RD;
    logic [31:0] MEM_WB_DATA;
    logic        ID_STALL;
    logic [31:0] ID_EX_NPC;
    logic [31:0] ID_EX_A;
    logic [31:0] ID_EX_B;
    logic [31:0] ID_EX_IMM;
    logic [4:0]  ID_EX_RT;
    logic [4:0]  ID_EX_RD;
    logic [5:0]  ID_EX_OPCODE;
    logic [5:0]  ID_EX_FUNCT;
    logic        ID_EX_REGWRITE;
    logic        ID_EX_MEMREAD;
    logic        ID_EX_VALID;

    int checks = 0;
    int errors = 0;
    vec_t vecs[5];
    vec_t zero_v;

    i_decode #(.NREGS(32), .DW(32)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .IF_ID_INSTR    (IF_ID_INSTR),
        .IF_ID_NPC      (IF_ID_NPC),
        .EX_MEM_PCSrc   (EX_MEM_PCSrc),
        .MEM_WB_REGWRITE(MEM_WB_REGWRITE),
        .MEM_WB_RD      (MEM_WB_RD),
        .MEM_WB_DATA    (MEM_WB_DATA),
        .ID_STALL       (ID_STALL),
        .ID_EX_NPC      (ID_EX_NPC),
        .ID_EX_A        (ID_EX_A),
        .ID_EX_B        (ID_EX_B),
        .ID_EX_IMM      (ID_EX_IMM),
        .ID_EX_RT       (ID_EX_RT),
        .ID_EX_RD       (ID_EX_RD),
        .ID_EX_OPCODE   (ID_EX_OPCODE),
        .ID_EX_FUNCT    (ID_EX_FUNCT),
        .ID_EX_REGWRITE (ID_EX_REGWRITE),
        .ID_EX_MEMREAD  (ID_EX_MEMREAD),
        .ID_EX_VALID    (ID_EX_VALID)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input vec_t v);
        chk({tag, ".npc"},   ID_EX_NPC, v.npc);
        chk({tag, ".a"},     ID_EX_A, v.a);
        chk({tag, ".b"},     ID_EX_B, v.b);
        chk({tag, ".imm"},   ID_EX_IMM, v.imm);
        chk({tag, ".rt"},    {27'd0, ID_EX_RT}, {27'd0, v.rt});
        chk({tag, ".rd"},    {27'd0, ID_EX_RD}, {27'd0, v.rd});
        chk({tag, ".opc"},   {26'd0, ID_EX_OPCODE}, {26'd0, v.opc});
        chk({tag, ".funct"}, {26'd0, ID_EX_FUNCT}, {26'd0, v.funct});
        chk({tag, ".rw"},    {31'd0, ID_EX_REGWRITE}, {31'd0, v.rw});
        chk({tag, ".mr"},    {31'd0, ID_EX_MEMREAD}, {31'd0, v.mr});
        chk({tag, ".valid"}, {31'd0, ID_EX_VALID}, {31'd0, v.valid});
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        IF_ID_INSTR     = 32'h0;
        MEM_WB_REGWRITE = 1'b1;
        MEM_WB_RD       = rd;
        MEM_WB_DATA     = data;
        tick();
        MEM_WB_REGWRITE = 1'b0;
    endtask

    initial begin
        zero_v = '0;
        //           instr          npc           st a             b             imm           rt     rd     opc    funct  rw mr v
        vecs[0] = '{32'h012DB820, 32'h0000_0100, 0, 32'h5,        32'h7,        32'hFFFFB820, 5'd13, 5'd23, 6'h00, 6'h20, 1, 0, 1};
        vecs[1] = '{32'h2128FFFC, 32'h0000_0104, 0, 32'h5,        32'h0,        32'hFFFFFFFC, 5'd8,  5'd31, 6'h08, 6'h3C, 1, 0, 1};
        vecs[2] = '{32'h21280004, 32'h0000_0108, 0, 32'h5,        32'h0,        32'h00000004, 5'd8,  5'd0,  6'h08, 6'h04, 1, 0, 1};
        vecs[3] = '{32'h8D2A0000, 32'h0000_010C, 0, 32'h5,        32'h55,       32'h00000000, 5'd10, 5'd0,  6'h23, 6'h00, 1, 1, 1};
        vecs[4] = '{32'h3C0B1234, 32'h0000_0110, 0, 32'h0,        32'h100,      32'h00001234, 5'd11, 5'd2,  6'h0F, 6'h34, 0, 0, 1};

        RST = 1'b1;
        IF_ID_INSTR = 32'h0;
        IF_ID_NPC = 32'h0;
        EX_MEM_PCSrc = 1'b0;
        MEM_WB_REGWRITE = 1'b0;
        MEM_WB_RD = 5'd0;
        MEM_WB_DATA = 32'h0;

        tick();
        tick();
        chk_ex("reset", zero_v);
        chk("reset.stall", {31'd0, ID_STALL}, 32'd0);
        RST = 1'b0;

        wb(5'd5, 32'h1234);
        IF_ID_INSTR = 32'h00A00000;
        tick();
        chk("wb_read.a", ID_EX_A, 32'h1234);
        chk("wb_read.valid", {31'd0, ID_EX_VALID}, 32'd1);

        wb(5'd9, 32'h5);
        wb(5'd13, 32'h7);
        wb(5'd10, 32'h55);
        wb(5'd11, 32'h100);

        for (int i = 0; i < 5; i++) begin
            IF_ID_INSTR = vecs[i].instr;
            IF_ID_NPC   = vecs[i].npc;
            #1;
            chk($sformatf("vec%0d.stall", i), {31'd0, ID_STALL}, {31'd0, vecs[i].stall});
            tick();
            chk_ex($sformatf("vec%0d", i), vecs[i]);
        end
        IF_ID_NPC = 32'h0;

        // load-use: one stall cycle, one bubble, then the add decodes normally
        IF_ID_INSTR = 32'h8D2A0000;
        tick();
        IF_ID_INSTR = 32'h014B6020;
        #1;
        chk("lu.stall1", {31'd0, ID_STALL}, 32'd1);
        tick();
        chk_ex("lu.bubble", zero_v);
        chk("lu.stall2", {31'd0, ID_STALL}, 32'd0);
        tick();
        chk_ex("lu.add", '{32'h014B6020, 32'h0, 0, 32'h55, 32'h100, 32'h00006020,
                           5'd11, 5'd12, 6'h00, 6'h20, 1, 0, 1});

        // flush during the stall cycle, with a write-back that must still commit
        IF_ID_INSTR = 32'h8D2A0000;
        tick();
        IF_ID_INSTR = 32'h014B6020;
        #1;
        chk("fl.stall_pre", {31'd0, ID_STALL}, 32'd1);
        EX_MEM_PCSrc    = 1'b1;
        MEM_WB_REGWRITE = 1'b1;
        MEM_WB_RD       = 5'd20;
        MEM_WB_DATA     = 32'hBEEF;
        #1;
        chk("fl.stall", {31'd0, ID_STALL}, 32'd0);
        tick();
        chk_ex("fl.bubble", zero_v);
        EX_MEM_PCSrc    = 1'b0;
        MEM_WB_REGWRITE = 1'b0;
        IF_ID_INSTR     = 32'h02800000;
        tick();
        chk("fl.wb_commit", ID_EX_A, 32'hBEEF);

        wb(5'd0, 32'hFFFF);
        IF_ID_INSTR = 32'h00000000;
        tick();
        chk("r0.a", ID_EX_A, 32'h0);
        chk("r0.b", ID_EX_B, 32'h0);

        // same-cycle write and read of reg 9
        IF_ID_INSTR     = 32'h012DB820;
        MEM_WB_REGWRITE = 1'b1;
        MEM_WB_RD       = 5'd9;
        MEM_WB_DATA     = 32'hAA;
        tick();
        MEM_WB_REGWRITE = 1'b0;
        chk("byp.a", ID_EX_A, EXP_BYP);
        chk("byp.b", ID_EX_B, 32'h7);
        tick();
        chk("byp.after", ID_EX_A, 32'hAA);

        // reset while a stall is pending
        IF_ID_INSTR = 32'h8D2A0000;
        tick();
        IF_ID_INSTR = 32'h014B6020;
        #1;
        chk("mrst.stall_pre", {31'd0, ID_STALL}, 32'd1);
        RST = 1'b1;
        #1;
        chk("mrst.stall", {31'd0, ID_STALL}, 32'd0);
        tick();
        chk_ex("mrst", zero_v);
        RST = 1'b0;
        IF_ID_INSTR = 32'h00A00000;
        tick();
        chk("mrst.regs_clear", ID_EX_A, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
